// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic pipeline-stage register: occupancy state
// encoding and the helper that derives it from the entry valid bits.
package pipe_stage_pkg;

    // Encoded as {main.valid, skid.valid}; ST_BAD is never reached in normal operation.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BAD   = 2'b01,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

    function automatic stage_state_e stage_state(input logic main_v, input logic skid_v);
        return stage_state_e'({main_v, skid_v});
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: valid bit plus control and data registers.
// Clear wins over load so a squash always empties the entry.
module pipe_slot
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [CTRL_WIDTH-1:0] d_ctrl,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic                  valid,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline-stage register between two LC-3b stages with flush and
// bubble insertion; SKID=1 adds a second entry so in_ready is a pure register output.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int          CTRL_WIDTH = 8,
    parameter int          DATA_WIDTH = 64,
    parameter int unsigned SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
);

    // Handshake: a word moves when valid & ready are both high at a rising edge;
    // valid never waits on ready, and a held word stays stable until it moves.

    logic                  main_v;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [DATA_WIDTH-1:0] main_data;
    logic                  skid_v;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  accept;
    logic                  out_xfer;
    logic                  main_load;
    logic                  main_clear;
    logic                  main_from_skid;
    logic                  skid_load;
    logic                  skid_clear;
    logic [CTRL_WIDTH-1:0] main_d_ctrl;
    logic [DATA_WIDTH-1:0] main_d_data;

    // Occupancy visible for checkers and debug.
    stage_state_e state;

    assign state    = stage_state(main_v, skid_v);
    assign accept   = in_valid & in_ready;
    assign out_xfer = main_v & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        main_clear     = flush;
        skid_clear     = flush;
        case (state)
            ST_EMPTY: begin
                main_load = accept;
            end
            ST_ONE: begin
                if (accept && (out_xfer || SKID == 0)) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    main_clear = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end
            end
            default: begin
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end
        endcase
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .CTRL_WIDTH (CTRL_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_v),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .CTRL_WIDTH (CTRL_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (skid_v),
                .ctrl   (skid_ctrl),
                .data   (skid_data)
            );
            // Registered ready: the stall path from downstream stops here.
            assign in_ready = ~skid_v;
        end else begin : g_single
            assign skid_v    = 1'b0;
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign in_ready  = ~main_v | out_ready;
        end
    endgenerate

    // Bubbles present an all-zero control word so downstream does nothing.
    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : '0;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: SKID=1 instance checked by an in-order scoreboard plus
// scenario checks, and a SKID=0 instance checked by its own scenario.
module tb_pipe_stage;

  localparam int CW = 8;
  localparam int DW = 64;
  localparam int EW = CW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  logic          s0_flush;
  logic          s0_in_valid;
  logic          s0_in_ready;
  logic [CW-1:0] s0_in_ctrl;
  logic [DW-1:0] s0_in_data;
  logic          s0_out_valid;
  logic          s0_out_ready;
  logic [CW-1:0] s0_out_ctrl;
  logic [DW-1:0] s0_out_data;

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] sb_exp;
  logic [DW-1:0] saved_data;

  always #5 clk = ~clk;

  pipe_stage #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  pipe_stage #(.CTRL_WIDTH(CW), .DATA_WIDTH(DW), .SKID(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .flush     (s0_flush),
    .in_valid  (s0_in_valid),
    .in_ready  (s0_in_ready),
    .in_ctrl   (s0_in_ctrl),
    .in_data   (s0_in_data),
    .out_valid (s0_out_valid),
    .out_ready (s0_out_ready),
    .out_ctrl  (s0_out_ctrl),
    .out_data  (s0_out_data)
  );

  // Scoreboard for the SKID=1 instance: push on accept, pop on transfer out.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got ctrl=%h data=%h, required nothing pending", out_ctrl, out_data);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({out_ctrl, out_data} !== sb_exp) begin
            bad++;
            $display("FAIL sb_order: got ctrl=%h data=%h, required ctrl=%h data=%h",
                     out_ctrl, out_data, sb_exp[EW-1:DW], sb_exp[DW-1:0]);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
    end
  end

  always @(posedge rst) exp_q.delete();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {$urandom(), $urandom()};
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b c=%h d=%h, required 0/00/0", out_valid, out_ctrl, out_data);
    end
    total++;
    if (in_ready !== 1'b1 || s0_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b/%b, required 1/1", in_ready, s0_in_ready);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i));
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_in_ready: cycle %0d got %b, required 1", i, in_ready);
      end
      if (i > 1) begin
        total++;
        if (out_valid !== 1'b1 || out_ctrl !== CW'(i - 1)) begin
          bad++;
          $display("FAIL stream_out: cycle %0d got v=%b c=%h, required 1/%h", i, out_valid, out_ctrl, CW'(i - 1));
        end
      end
      cyc();
    end
    drive(1'b0, 8'h00);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 8'h08) begin
      bad++;
      $display("FAIL stream_last: got v=%b c=%h, required 1/08", out_valid, out_ctrl);
    end
    cyc();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
      bad++;
      $display("FAIL stream_empty: got v=%b c=%h, required 0/00", out_valid, out_ctrl);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] exp_seq [3];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h12; exp_seq[2] = 8'h13;
    out_ready = 1'b0;
    drive(1'b1, 8'h11);
    cyc();
    drive(1'b1, 8'h12);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_ctrl !== 8'h11) begin
      bad++;
      $display("FAIL bp_one: got rdy=%b c=%h, required 1/11", in_ready, out_ctrl);
    end
    cyc();
    drive(1'b1, 8'h13);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ctrl !== 8'h11) begin
      bad++;
      $display("FAIL bp_full: got rdy=%b v=%b c=%h, required 0/1/11", in_ready, out_valid, out_ctrl);
    end
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_ctrl !== exp_seq[i] || in_ready !== (i != 0)) begin
        bad++;
        $display("FAIL bp_release: step %0d got v=%b c=%h rdy=%b, required 1/%h/%b",
                 i, out_valid, out_ctrl, in_ready, exp_seq[i], (i != 0));
      end
      cyc();
      if (i == 1) drive(1'b0, 8'h00);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got v=%b pending=%0d, required 0/0", out_valid, exp_q.size());
    end
    cyc();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 8'h31);
    cyc();
    drive(1'b1, 8'h32);
    cyc();
    drive(1'b1, 8'h33);
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_full_rdy: got %b, required 0", in_ready);
    end
    cyc();
    flush = 1'b0;
    drive(1'b1, 8'h34);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_full_after: got v=%b c=%h rdy=%b, required 0/00/1", out_valid, out_ctrl, in_ready);
    end
    cyc();
    drive(1'b1, 8'h35);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b1, 8'h36);
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
      bad++;
      $display("FAIL flush_drop_accept: got v=%b c=%h, required 0/00", out_valid, out_ctrl);
    end
    cyc();
    drive(1'b0, 8'h00);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 8'h36) begin
      bad++;
      $display("FAIL flush_resume: got v=%b c=%h, required 1/36", out_valid, out_ctrl);
    end
    cyc();
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b1, 8'h21);
    cyc();
    drive(1'b0, 8'h00);
    @(negedge clk);
    total++;
    if (out_ctrl !== 8'h21) begin
      bad++;
      $display("FAIL bubble_first: got c=%h, required 21", out_ctrl);
    end
    cyc();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) drive(1'b1, 8'h22);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
        bad++;
        $display("FAIL bubble_nop: cycle %0d got v=%b c=%h, required 0/00", i, out_valid, out_ctrl);
      end
      cyc();
    end
    drive(1'b0, 8'h00);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 8'h22) begin
      bad++;
      $display("FAIL bubble_second: got v=%b c=%h, required 1/22", out_valid, out_ctrl);
    end
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom_range(1, 255)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      if (!out_valid) begin
        total++;
        if (out_ctrl !== 8'h00) begin
          bad++;
          $display("FAIL rand_nop: cycle %0d got c=%h, required 00", i, out_ctrl);
        end
      end
      cyc();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cyc();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: got v=%b pending=%0d, required 0/0", out_valid, exp_q.size());
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 8'h61);
    in_data = 64'hDEAD_BEEF_0123_4567;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: got v=%b c=%h d=%h rdy=%b, required 0/00/0/1", out_valid, out_ctrl, out_data, in_ready);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_early: got v=%b, required 0", out_valid);
    end
    cyc();
    drive(1'b0, 8'h00);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_ctrl !== 8'h61) begin
      bad++;
      $display("FAIL reset_first_accept: got v=%b c=%h, required 1/61", out_valid, out_ctrl);
    end
    out_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_skid0();
    s0_flush     = 1'b0;
    s0_out_ready = 1'b0;
    s0_in_valid  = 1'b1;
    s0_in_ctrl   = 8'h51;
    s0_in_data   = {$urandom(), $urandom()};
    @(negedge clk);
    total++;
    if (s0_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL s0_empty_rdy: got %b, required 1", s0_in_ready);
    end
    cyc();
    s0_in_ctrl = 8'h52;
    s0_in_data = {$urandom(), $urandom()};
    saved_data = s0_in_data;
    #1;
    total++;
    if (s0_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL s0_stall_rdy: got %b, required 0", s0_in_ready);
    end
    s0_out_ready = 1'b1;
    #1;
    total++;
    if (s0_in_ready !== 1'b1 || s0_out_ctrl !== 8'h51) begin
      bad++;
      $display("FAIL s0_release_rdy: got rdy=%b c=%h, required 1/51", s0_in_ready, s0_out_ctrl);
    end
    cyc();
    s0_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s0_out_valid !== 1'b1 || s0_out_ctrl !== 8'h52 || s0_out_data !== saved_data) begin
      bad++;
      $display("FAIL s0_replace: got v=%b c=%h d=%h, required 1/52/%h", s0_out_valid, s0_out_ctrl, s0_out_data, saved_data);
    end
    cyc();
    @(negedge clk);
    total++;
    if (s0_out_valid !== 1'b0 || s0_out_ctrl !== 8'h00) begin
      bad++;
      $display("FAIL s0_empty: got v=%b c=%h, required 0/00", s0_out_valid, s0_out_ctrl);
    end
    s0_out_ready = 1'b0;
    s0_in_valid = 1'b1;
    s0_in_ctrl = 8'h53;
    cyc();
    s0_out_ready = 1'b1;
    s0_in_ctrl = 8'h54;
    s0_flush = 1'b1;
    cyc();
    s0_flush = 1'b0;
    s0_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (s0_out_valid !== 1'b0 || s0_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL s0_flush: got v=%b rdy=%b, required 0/1", s0_out_valid, s0_in_ready);
    end
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_ready = 1'b0;
    s0_flush = 1'b0;
    s0_in_valid = 1'b0;
    s0_in_ctrl = '0;
    s0_in_data = '0;
    s0_out_ready = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
    test_reset_mid();
    test_skid0();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
